v_decode: RTL

- Instruction-decode stage directly upstream of the instruction buffer (i_buffer).
- Accepts one 32-bit instruction word at a time from fetch over a valid/vacant handshake.
- Splits the word into opt/funct3/funct6/rs1/rs2/rd fields and builds the sign-extended immediate for scalar RV32I and RVV formats.
- Registers the result and delivers it to the instruction buffer using that buffer's one-cycle valid pulse protocol.

---
 rtl/v_decode_if.sv | 29 ++
 rtl/v_decode.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/v_decode_if.sv
// Handshake bundle between fetch, v_decode and i_buffer.
// The decoder connects through the slave modport; fetch/i_buffer (or a bench) use master.
`timescale 1ns/1ps
interface v_decode_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        if_vacant;
    logic        ib_vacant;
    logic        ib_valid;
    logic [6:0]  ib_opt;
    logic [2:0]  ib_funct3;
    logic [5:0]  ib_funct6;
    logic [4:0]  ib_rs1;
    logic [4:0]  ib_rs2;
    logic [4:0]  ib_rd;
    logic [31:0] ib_imm;

    modport slave (
        input  if_valid, if_inst, ib_vacant,
        output if_vacant, ib_valid, ib_opt, ib_funct3, ib_funct6,
               ib_rs1, ib_rs2, ib_rd, ib_imm
    );

    modport master (
        output if_valid, if_inst, ib_vacant,
        input  if_vacant, ib_valid, ib_opt, ib_funct3, ib_funct6,
               ib_rs1, ib_rs2, ib_rd, ib_imm
    );
endinterface

// File: rtl/v_decode.sv
// v_decode: RV32I/RVV decode stage; registers decoded fields and pulses them into i_buffer.
// Optional macro V_DECODE_ILLEGAL_EN adds a sticky illegal flag and saturating illegal_cnt.
`timescale 1ns/1ps
module v_decode
`ifdef V_DECODE_ILLEGAL_EN
#(
    parameter int CNT_WID = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    v_decode_if.slave  bus
`ifdef V_DECODE_ILLEGAL_EN
    ,
    output logic               illegal,
    output logic [CNT_WID-1:0] illegal_cnt
`endif
);

    localparam logic [6:0] OPC_R  = 7'h33;
    localparam logic [6:0] OPC_I  = 7'h13;
    localparam logic [6:0] OPC_L  = 7'h03;
    localparam logic [6:0] OPC_S  = 7'h23;
    localparam logic [6:0] OPC_B  = 7'h63;
    localparam logic [6:0] OPC_VA = 7'h57;
    localparam logic [6:0] OPC_VL = 7'h07;
    localparam logic [6:0] OPC_VS = 7'h27;

    typedef enum logic [1:0] {IDLE, DROP, WAIT_IB, SENT} state_e;

    typedef struct packed {
        logic [6:0]  opt;
        logic [2:0]  funct3;
        logic [5:0]  funct6;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } fields_t;

    state_e      state_q, state_d;
    logic        if_vacant_q, if_vacant_d;
    logic        ib_valid_q, ib_valid_d;
    fields_t     fields_q, fields_d;
    fields_t     dec_fields;
    logic        dec_legal;
    logic [31:0] inst;

    assign inst = bus.if_inst;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec_fields     = '0;
        dec_fields.opt = inst[6:0];
        dec_legal      = 1'b1;
        unique case (inst[6:0])
            OPC_R: begin
                dec_fields.funct3 = inst[14:12];
                dec_fields.rs1    = inst[19:15];
                dec_fields.rs2    = inst[24:20];
                dec_fields.rd     = inst[11:7];
            end
            OPC_I, OPC_L: begin
                dec_fields.funct3 = inst[14:12];
                dec_fields.rs1    = inst[19:15];
                dec_fields.rd     = inst[11:7];
                dec_fields.imm    = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_S: begin
                dec_fields.funct3 = inst[14:12];
                dec_fields.rs1    = inst[19:15];
                dec_fields.rs2    = inst[24:20];
                dec_fields.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_B: begin
                dec_fields.funct3 = inst[14:12];
                dec_fields.rs1    = inst[19:15];
                dec_fields.rs2    = inst[24:20];
                dec_fields.imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                     inst[11:8], 1'b0};
            end
            OPC_VA, OPC_VL, OPC_VS: begin
                dec_fields.funct3 = inst[14:12];
                dec_fields.funct6 = inst[31:26];
                dec_fields.rs1    = inst[19:15];
                dec_fields.rs2    = inst[24:20];
                dec_fields.rd     = inst[11:7];
                // OPIVI carries a 5-bit signed immediate in the vs1 slot
                if (inst[6:0] == OPC_VA && inst[14:12] == 3'b011) begin
                    dec_fields.imm = {{27{inst[19]}}, inst[19:15]};
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        if_vacant_d = if_vacant_q;
        ib_valid_d  = ib_valid_q;
        fields_d    = fields_q;
        unique case (state_q)
            IDLE: begin
                ib_valid_d = 1'b0;
                if (bus.if_valid) begin
                    fields_d    = dec_fields;
                    if_vacant_d = 1'b0;
                    state_d     = dec_legal ? WAIT_IB : DROP;
                end
            end
            DROP: begin
                if_vacant_d = 1'b1;
                state_d     = IDLE;
            end
            WAIT_IB: begin
                if (bus.ib_vacant) begin
                    ib_valid_d = 1'b1;
                    state_d    = SENT;
                end
            end
            SENT: begin
                ib_valid_d  = 1'b0;
                if_vacant_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            if_vacant_q <= 1'b1;
            ib_valid_q  <= 1'b0;
            fields_q    <= '0;
        end else begin
            state_q     <= state_d;
            if_vacant_q <= if_vacant_d;
            ib_valid_q  <= ib_valid_d;
            fields_q    <= fields_d;
        end
    end

    assign bus.if_vacant = if_vacant_q;
    assign bus.ib_valid  = ib_valid_q;
    assign bus.ib_opt    = fields_q.opt;
    assign bus.ib_funct3 = fields_q.funct3;
    assign bus.ib_funct6 = fields_q.funct6;
    assign bus.ib_rs1    = fields_q.rs1;
    assign bus.ib_rs2    = fields_q.rs2;
    assign bus.ib_rd     = fields_q.rd;
    assign bus.ib_imm    = fields_q.imm;

`ifdef V_DECODE_ILLEGAL_EN
    logic               illegal_q, illegal_d;
    logic [CNT_WID-1:0] illegal_cnt_q, illegal_cnt_d;
    logic               drop_evt;

    assign drop_evt = (state_q == IDLE) && bus.if_valid && !dec_legal;

    always_comb begin
        illegal_d     = illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (drop_evt) begin
            illegal_d = 1'b1;
            if (illegal_cnt_q != '1) begin
                illegal_cnt_d = illegal_cnt_q + CNT_WID'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
